// File: rtl/leaf_spine_tx.sv
// Leaf-to-spine transmit port: flit buffer plus credit-based flow control.
// Flits are sent only while the spine has free input-FIFO entries.
module leaf_spine_tx #(
  parameter int DWIDTH     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CREDITS    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DWIDTH-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [DWIDTH-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          credit_return,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [6:0]                    credit_count,
  output logic                          credit_err
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [6:0] CRED = 7'(CREDITS);

  localparam logic [1:0] INIT   = 2'd0;
  localparam logic [1:0] IDLE   = 2'd1;
  localparam logic [1:0] SEND   = 2'd2;
  localparam logic [1:0] NOCRED = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [6:0]        cred_q, cred_d;
  logic              err_q, err_d;
  logic              ovalid_q, ovalid_d;
  logic [DWIDTH-1:0] odata_q, odata_d;
  logic [DWIDTH-1:0] mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic ret;

  assign in_ready = (cnt_q < CW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready;
  // IDLE pops directly so a lone flit leaves one edge after its push.
  assign pop      = ((state_q == IDLE) || (state_q == SEND)) &&
                    (cnt_q != '0) && (cred_q != '0);
  assign ret      = credit_return && (state_q != INIT);

  // Buffer pointers, occupancy and output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovalid_d = pop;
    odata_d  = odata_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      odata_d  = mem_q[rd_ptr_q];
    end
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!push && pop) cnt_d = cnt_q - CW'(1);
  end

  // Credit accounting; an unmatched return at full credit is an overflow.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    if (state_q == INIT) begin
      cred_d = CRED;
    end else if (ret && !pop) begin
      if (cred_q >= CRED) err_d = 1'b1;
      else cred_d = cred_q + 7'd1;
    end else if (!ret && pop) begin
      cred_d = cred_q - 7'd1;
    end
  end

  // Transmit state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT: state_d = IDLE;
      IDLE: begin
        if (cnt_q != '0) begin
          if (cred_q != '0) state_d = SEND;
          else state_d = NOCRED;
        end
      end
      SEND: begin
        if (cnt_q == '0) state_d = IDLE;
        else if (cred_q == '0) state_d = NOCRED;
      end
      NOCRED: if (cred_q != '0) state_d = SEND;
      default: state_d = INIT;
    endcase
  end

  // Control and output state, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      cred_q   <= '0;
      err_q    <= 1'b0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      cred_q   <= cred_d;
      err_q    <= err_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
    end
  end

  // Flit storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data     = odata_q;
  assign out_valid    = ovalid_q;
  assign fifo_count   = cnt_q;
  assign credit_count = cred_q;
  assign credit_err   = err_q;

endmodule

// File: tb/tb_leaf_spine_tx.sv
// Directed bench for leaf_spine_tx.
// Flits seen on out_valid are logged at the falling edge.
module tb_leaf_spine_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        credit_return;
  logic [3:0]  fifo_count;
  logic [6:0]  credit_count;
  logic        credit_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [15:0] got [$];
  int          gcyc [$];

  leaf_spine_tx dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .credit_return(credit_return),
    .fifo_count   (fifo_count),
    .credit_count (credit_count),
    .credit_err   (credit_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      got.push_back(out_data);
      gcyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic cret();
    credit_return = 1'b1;
    step();
    credit_return = 1'b0;
  endtask

  logic [15:0] exp37 [8];
  logic        bad;
  logic        seen;

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = '0;
    credit_return = 1'b0;
    exp37 = '{16'h3609, 16'h360A, 16'h360B, 16'h3700,
              16'h3701, 16'h3702, 16'h3703, 16'h3704};

    // reset values
    step();
    step();
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_credit", 32'(credit_count), 32'd0);
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    reset = 1'b0;
    step();
    chk("init_credit", 32'(credit_count), 32'd8);

    // single flit, minimum latency
    got.delete();
    gcyc.delete();
    push(16'h1A01);
    chk("lat_novalid", 32'(out_valid), 32'd0);
    chk("lat_count", 32'(fifo_count), 32'd1);
    step();
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'h1A01);
    chk("lat_credit", 32'(credit_count), 32'd7);
    step();
    chk("lat_drop", 32'(out_valid), 32'd0);
    chk("lat_hold", 32'(out_data), 32'h1A01);
    chk("lat_n", 32'(got.size()), 32'd1);
    cret();
    chk("ret_credit", 32'(credit_count), 32'd8);
    chk("ret_err", 32'(credit_err), 32'd0);

    // 12 back-to-back flits with 8 credits
    got.delete();
    gcyc.delete();
    for (int i = 0; i < 12; i++) push(16'h3600 + 16'(i));
    chk("b2b_count", 32'(fifo_count), 32'd4);
    chk("b2b_credit", 32'(credit_count), 32'd0);
    chk("b2b_n", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      chk("b2b_consec", 32'(gcyc[7] - gcyc[0]), 32'd7);
      bad = 1'b0;
      for (int i = 0; i < 8; i++) if (got[i] != 16'h3600 + 16'(i)) bad = 1'b1;
      chk("b2b_order", 32'(bad), 32'd0);
    end
    repeat (3) step();
    chk("nocred_hold", 32'(got.size()), 32'd8);
    cret();
    repeat (6) step();
    chk("one_more_n", 32'(got.size()), 32'd9);
    if (got.size() == 9) chk("one_more_data", 32'(got[8]), 32'h3608);
    chk("one_more_count", 32'(fifo_count), 32'd3);

    // fill to full during NOCRED, drop overflow, drain in order
    got.delete();
    gcyc.delete();
    for (int i = 0; i < 5; i++) push(16'h3700 + 16'(i));
    chk("full_count", 32'(fifo_count), 32'd8);
    chk("full_ready", 32'(in_ready), 32'd0);
    push(16'h37FF);
    chk("full_drop", 32'(fifo_count), 32'd8);
    chk("full_err", 32'(credit_err), 32'd0);
    credit_return = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 3) chk("cr_pop_a3", 32'(credit_count), 32'd2);
      if (i == 4) chk("cr_pop_a4", 32'(credit_count), 32'd2);
    end
    credit_return = 1'b0;
    repeat (8) step();
    chk("wrap_n", 32'(got.size()), 32'd8);
    if (got.size() == 8) begin
      bad = 1'b0;
      for (int i = 0; i < 8; i++) if (got[i] != exp37[i]) bad = 1'b1;
      chk("wrap_order", 32'(bad), 32'd0);
    end
    chk("wrap_count", 32'(fifo_count), 32'd0);
    chk("wrap_credit", 32'(credit_count), 32'd0);
    chk("wrap_ready", 32'(in_ready), 32'd1);

    // credit overflow
    repeat (8) cret();
    chk("sat_pre", 32'(credit_count), 32'd8);
    chk("sat_pre_err", 32'(credit_err), 32'd0);
    cret();
    chk("sat_credit", 32'(credit_count), 32'd8);
    chk("sat_err", 32'(credit_err), 32'd1);
    step();
    chk("sat_sticky", 32'(credit_err), 32'd1);

    // reset mid-transfer
    for (int i = 0; i < 8; i++) push(16'h3800 + 16'(i));
    repeat (3) step();
    chk("drain_credit", 32'(credit_count), 32'd0);
    for (int i = 0; i < 6; i++) push(16'h3900 + 16'(i));
    chk("mid_count6", 32'(fifo_count), 32'd6);
    cret();
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = out_valid;
    end
    chk("mid_wait", 32'(seen), 32'd1);
    chk("mid_count5", 32'(fifo_count), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data", 32'(out_data), 32'd0);
    chk("arst_credit", 32'(credit_count), 32'd0);
    chk("arst_err", 32'(credit_err), 32'd0);
    chk("arst_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;
    chk("rel_credit0", 32'(credit_count), 32'd0);
    step();
    chk("rel_credit8", 32'(credit_count), 32'd8);
    chk("rel_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
